// File: rtl/duty_button_ctrl.sv
// Two-button front end for the PWM stage: sync, debounce, auto-repeat, then one-cycle steps.
// Press-to-step latency is 2 + DEB_CYCLES + 1 cycles; steps are held pending while en=0 and coalesce.

module duty_btn_chan #(
  parameter int CNT_W         = 20,
  parameter int DEB_CYCLES    = 50000,
  parameter int REPEAT_DELAY  = 500000,
  parameter int REPEAT_PERIOD = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_s,
  output logic o_req,
  output logic o_active
);

  typedef enum logic [2:0] {IDLE, PRESS_DB, HELD, REPEAT, REL_DB} state_t;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic             r_s1;
  logic             r_s2;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_btn;
      r_s2 <= r_s1;
    end
  end

  assign o_s      = r_s2;
  assign o_active = (r_state != IDLE);

  // req is decoded from the transition condition so the step lands in pending on the transition edge.
  always_comb begin
    o_req = 1'b0;
    case (r_state)
      PRESS_DB: o_req = r_s2 && (r_cnt == DEB_LAST);
      HELD:     o_req = r_s2 && (r_cnt == DLY_LAST);
      REPEAT:   o_req = r_s2 && (r_cnt == PER_LAST);
      default:  o_req = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_s2) begin
            r_state <= PRESS_DB;
            r_cnt   <= '0;
          end
        end
        PRESS_DB: begin
          if (!r_s2) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == DEB_LAST) begin
            r_state <= HELD;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        HELD: begin
          if (!r_s2) begin
            r_state <= REL_DB;
            r_cnt   <= '0;
          end else if (r_cnt == DLY_LAST) begin
            r_state <= REPEAT;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        REPEAT: begin
          if (!r_s2) begin
            r_state <= REL_DB;
            r_cnt   <= '0;
          end else if (r_cnt == PER_LAST) begin
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        REL_DB: begin
          // A bounce back to 1 during release resumes the hold without issuing a step.
          if (r_s2) begin
            r_state <= HELD;
            r_cnt   <= '0;
          end else if (r_cnt == DEB_LAST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

module duty_button_ctrl #(
  parameter int CNT_W         = 20,
  parameter int DEB_CYCLES    = 50000,
  parameter int REPEAT_DELAY  = 500000,
  parameter int REPEAT_PERIOD = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic btn_up,
  input  logic btn_dn,
  output logic duty_inc,
  output logic duty_dec,
  output logic busy
);

  logic w_s_up, w_s_dn;
  logic w_raw_req_up, w_raw_req_dn;
  logic w_act_up, w_act_dn;
  logic w_req_up, w_req_dn;
  logic w_grant_up, w_grant_dn;
  logic r_pend_up, r_pend_dn;
  logic r_duty_inc, r_duty_dec, r_busy;

  duty_btn_chan #(
    .CNT_W(CNT_W), .DEB_CYCLES(DEB_CYCLES),
    .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_up (
    .clk(clk), .rst(rst), .i_btn(btn_up),
    .o_s(w_s_up), .o_req(w_raw_req_up), .o_active(w_act_up)
  );

  duty_btn_chan #(
    .CNT_W(CNT_W), .DEB_CYCLES(DEB_CYCLES),
    .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_dn (
    .clk(clk), .rst(rst), .i_btn(btn_dn),
    .o_s(w_s_dn), .o_req(w_raw_req_dn), .o_active(w_act_dn)
  );

  // Both buttons down is ambiguous intent: drop steps from both sides while it lasts.
  assign w_req_up   = w_raw_req_up & ~(w_s_up & w_s_dn);
  assign w_req_dn   = w_raw_req_dn & ~(w_s_up & w_s_dn);
  assign w_grant_up = r_pend_up & en;
  assign w_grant_dn = r_pend_dn & en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend_up  <= 1'b0;
      r_pend_dn  <= 1'b0;
      r_duty_inc <= 1'b0;
      r_duty_dec <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_pend_up  <= w_req_up | (r_pend_up & ~w_grant_up);
      r_pend_dn  <= w_req_dn | (r_pend_dn & ~w_grant_dn);
      r_duty_inc <= w_grant_up & ~w_grant_dn;
      r_duty_dec <= w_grant_dn & ~w_grant_up;
      r_busy     <= w_act_up | w_act_dn;
    end
  end

  assign duty_inc = r_duty_inc;
  assign duty_dec = r_duty_dec;
  assign busy     = r_busy;

endmodule

// File: tb/tb_duty_button_ctrl.sv
// Directed bench for duty_button_ctrl with short timing parameters (DEB=4, DELAY=10, PERIOD=5).
module tb_duty_button_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic btn_up = 1'b0;
  logic btn_dn = 1'b0;
  logic duty_inc, duty_dec, busy;

  int n_chk = 0;
  int n_err = 0;
  logic [63:0] obs_inc, obs_dec, obs_busy;

  duty_button_ctrl #(
    .CNT_W(8), .DEB_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(5)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .btn_up(btn_up), .btn_dn(btn_dn),
    .duty_inc(duty_inc), .duty_dec(duty_dec), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] span(input int start, input int len);
    logic [63:0] m = '0;
    for (int i = start; i < start + len && i < 64; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Bit i of each mask is the input level sampled at edge i; bit i of obs_* is the output after edge i.
  task automatic run(input int n, input logic [63:0] up_m, input logic [63:0] dn_m,
                     input logic [63:0] en_m);
    obs_inc  = '0;
    obs_dec  = '0;
    obs_busy = '0;
    for (int i = 0; i < n; i++) begin
      btn_up = up_m[i];
      btn_dn = dn_m[i];
      en     = en_m[i];
      tick;
      obs_inc[i]  = duty_inc;
      obs_dec[i]  = duty_dec;
      obs_busy[i] = busy;
    end
  endtask

  task automatic settle(input string tag);
    int k = 0;
    btn_up = 1'b0;
    btn_dn = 1'b0;
    en     = 1'b1;
    while (busy && k < 200) begin
      tick;
      k++;
    end
    repeat (4) tick;
    chk(tag, 64'(busy), 64'd0);
  endtask

  initial begin
    #2 rst = 1'b0;
    #1;
    chk("rst_inc", 64'(duty_inc), 64'd0);
    chk("rst_dec", 64'(duty_dec), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    settle("settle0");

    // 1: glitch shorter than debounce
    run(20, span(0, 3), '0, '1);
    chk("t1_inc", obs_inc, 64'd0);
    chk("t1_busy", obs_busy, 64'h38);
    settle("settle1");

    // 2: long hold with auto-repeat
    run(60, span(0, 40), '0, '1);
    chk("t2_inc", obs_inc, (64'd1 << 7) | (64'd1 << 17) | (64'd1 << 22) | (64'd1 << 27) |
                           (64'd1 << 32) | (64'd1 << 37) | (64'd1 << 42));
    chk("t2_dec", obs_dec, 64'd0);
    settle("settle2");

    // 3: step held pending until en rises
    run(40, '0, span(0, 8), span(28, 36));
    chk("t3_dec", obs_dec, 64'd1 << 28);
    chk("t3_inc", obs_inc, 64'd0);
    settle("settle3");

    // 4a: both pressed in the same cycle
    run(60, span(0, 40), span(0, 40), '1);
    chk("t4a_inc", obs_inc, 64'd0);
    chk("t4a_dec", obs_dec, 64'd0);
    settle("settle4a");

    // 4b: both pending, granted in the same cycle
    run(60, span(0, 8), span(20, 8), span(45, 19));
    chk("t4b_inc", obs_inc, 64'd0);
    chk("t4b_dec", obs_dec, 64'd0);
    settle("settle4b");

    // 4c: staggered press, overlapping hold
    run(50, span(0, 30), span(2, 28), '1);
    chk("t4c_inc", obs_inc, 64'd0);
    chk("t4c_dec", obs_dec, 64'd0);
    settle("settle4c");

    // 5: reset while in REPEAT with a step pending
    run(21, '1, '0, '0);
    chk("t5_pre_inc", obs_inc, 64'd0);
    chk("t5_pre_busy", 64'(busy), 64'd1);
    rst = 1'b0;
    #1;
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_inc", 64'(duty_inc), 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    run(10, '1, '0, '1);
    chk("t5_restart", obs_inc, 64'd1 << 7);
    run(30, '0, '0, '1);
    chk("t5_release", obs_inc, 64'd0);
    settle("settle5");

    // 6: bouncing press 1,0,1,1,0,1 then stable high from edge 5
    run(30, '0, 64'h2D | span(5, 11), '1);
    chk("t6_dec", obs_dec, 64'd1 << 12);
    chk("t6_inc", obs_inc, 64'd0);
    settle("settle6");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
